// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI initiator.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, WAIT} spi_state_t;
  localparam int SPI_W_DEFAULT   = 8;
  localparam int SPI_DIV_DEFAULT = 4;
endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: pulses tick every DIV clk cycles while ena=1, held at zero otherwise.
module spi_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  output logic tick
);
  localparam int CW = $clog2(DIV) + 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = ena && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!ena || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_master_tx.sv
// Mode-0 byte SPI initiator: MSB-first shift out on mosi, miso captured into bus_out.
// Define SPI_MASTER_TX_BURST_EN to add the hold port and the WAIT state (cs_n kept low between words).
module spi_master_tx import spi_pkg::*; #(
  parameter int W   = SPI_W_DEFAULT,
  parameter int DIV = SPI_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] bus_in,
  output logic [W-1:0] bus_out,
  output logic         busy,
  output logic         req,
  output logic         sck,
  output logic         cs_n,
  output logic         mosi,
  input  logic         miso
`ifdef SPI_MASTER_TX_BURST_EN
  , input logic        hold
`endif
);
  localparam int BW = $clog2(W) + 1;

  spi_state_t    state_q, state_d;
  logic [W-1:0]  sr_q, sr_d, bus_out_q, bus_out_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          miso_q, miso_d, sck_q, sck_d, mosi_q, mosi_d, req_q, req_d;
  logic          tick, div_ena;

  assign div_ena = (state_q != IDLE) && (state_q != WAIT);

  spi_clk_div #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .ena  (div_ena),
    .tick (tick)
  );

  assign busy    = div_ena;
  assign cs_n    = (state_q == IDLE) || (state_q == GAP);
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign req     = req_q;
  assign bus_out = bus_out_q;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bcnt_d    = bcnt_q;
    miso_d    = miso_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    req_d     = 1'b0;
    bus_out_d = bus_out_q;
    case (state_q)
      IDLE: if (start) begin
        sr_d    = bus_in;
        bcnt_d  = '0;
        mosi_d  = bus_in[W-1];
        state_d = SETUP;
      end
      SETUP: if (tick) state_d = SHIFT;
      SHIFT: if (tick) begin
        if (!sck_q) begin
          sck_d  = 1'b1;
          miso_d = miso;
        end else begin
          // Captured bit is held aside so the untransmitted LSB of sr_q survives until shifted up.
          sck_d  = 1'b0;
          sr_d   = {sr_q[W-2:0], miso_q};
          bcnt_d = bcnt_q + 1'b1;
          mosi_d = sr_q[W-2];
          if (bcnt_q == BW'(W - 1)) begin
            bus_out_d = {sr_q[W-2:0], miso_q};
            req_d     = 1'b1;
            mosi_d    = 1'b0;
            state_d   = GAP;
`ifdef SPI_MASTER_TX_BURST_EN
            if (hold) state_d = WAIT;
`endif
          end
        end
      end
      GAP: if (tick) state_d = IDLE;
`ifdef SPI_MASTER_TX_BURST_EN
      WAIT: begin
        if (start) begin
          sr_d    = bus_in;
          bcnt_d  = '0;
          mosi_d  = bus_in[W-1];
          state_d = SETUP;
        end else if (!hold) begin
          state_d = GAP;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bcnt_q    <= '0;
      miso_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      req_q     <= 1'b0;
      bus_out_q <= '0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bcnt_q    <= bcnt_d;
      miso_q    <= miso_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      req_q     <= req_d;
      bus_out_q <= bus_out_d;
    end
  end
endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: instance 0 at DIV=2, instance 1 at DIV=1, both W=8.
module tb_spi_master_tx;
  localparam int W = 8;
  localparam int DIVS [2] = '{2, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a [2];
  logic [7:0] bus_in_a [2];
  logic [7:0] bus_out_a [2];
  logic       busy_a [2], req_a [2], sck_a [2], cs_n_a [2], mosi_a [2], miso_a [2];
`ifdef SPI_MASTER_TX_BURST_EN
  logic       hold_a [2];
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_tx #(.W(W), .DIV(DIVS[0])) dut (
    .clk(clk), .rst(rst), .start(start_a[0]), .bus_in(bus_in_a[0]), .bus_out(bus_out_a[0]),
    .busy(busy_a[0]), .req(req_a[0]), .sck(sck_a[0]), .cs_n(cs_n_a[0]), .mosi(mosi_a[0]),
    .miso(miso_a[0])
`ifdef SPI_MASTER_TX_BURST_EN
    , .hold(hold_a[0])
`endif
  );

  spi_master_tx #(.W(W), .DIV(DIVS[1])) dut1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .bus_in(bus_in_a[1]), .bus_out(bus_out_a[1]),
    .busy(busy_a[1]), .req(req_a[1]), .sck(sck_a[1]), .cs_n(cs_n_a[1]), .mosi(mosi_a[1]),
    .miso(miso_a[1])
`ifdef SPI_MASTER_TX_BURST_EN
    , .hold(hold_a[1])
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word: mosi bits seen at sck rises must equal din, bus_out must equal the miso word
  // (or din in loopback), done pulse (2W+1)*DIV cycles after the accepting edge.
  task automatic xfer(input int s, input logic [7:0] din, input logic [7:0] mw, input bit lb);
    int c, rises, low;
    logic [7:0] tx;
    logic psck;
    bit hl;
    hl = 1'b0;
`ifdef SPI_MASTER_TX_BURST_EN
    hl = hold_a[s];
`endif
    bus_in_a[s] = din;
    miso_a[s]   = lb ? din[7] : mw[7];
    start_a[s]  = 1'b1;
    step();
    start_a[s] = 1'b0;
    c = 0; rises = 0; low = 0; tx = '0; psck = 1'b0;
    while (!req_a[s] && c < 400) begin
      if (!cs_n_a[s]) low++;
      if (sck_a[s] && !psck) begin
        tx = {tx[6:0], mosi_a[s]};
        rises++;
      end
      psck = sck_a[s];
      miso_a[s] = lb ? mosi_a[s] : (rises < 8 ? mw[3'(7 - rises)] : 1'b0);
      step();
      c++;
    end
    chk($sformatf("latency_s%0d", s), c, (2 * W + 1) * DIVS[s]);
    chk($sformatf("bus_out_s%0d", s), bus_out_a[s], lb ? din : mw);
    chk($sformatf("mosi_bits_s%0d", s), tx, din);
    chk($sformatf("sck_rises_s%0d", s), rises, W);
    chk($sformatf("cs_low_cycles_s%0d", s), low, (2 * W + 1) * DIVS[s]);
    chk($sformatf("cs_n_at_req_s%0d", s), cs_n_a[s], !hl);
    if (hl) begin
      chk("busy_in_wait", busy_a[s], 1'b0);
      step();
      chk("req_one_cycle", req_a[s], 1'b0);
      chk("cs_n_held_in_wait", cs_n_a[s], 1'b0);
    end else begin
      for (int k = 1; k <= DIVS[s]; k++) begin
        step();
        if (k == 1) chk($sformatf("req_one_cycle_s%0d", s), req_a[s], 1'b0);
        chk($sformatf("gap_cs_n_s%0d", s), cs_n_a[s], 1'b1);
        if (k < DIVS[s]) chk($sformatf("gap_busy_s%0d", s), busy_a[s], 1'b1);
      end
      chk($sformatf("idle_busy_s%0d", s), busy_a[s], 1'b0);
    end
  endtask

  initial begin
    int rises, hi, nacc, guard;
    logic psck, pcs, seen_low;
    logic [7:0] q[$];
    logic [7:0] exp_w;

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start_a[s] = 1'b0; bus_in_a[s] = 8'hFF; miso_a[s] = 1'b1;
`ifdef SPI_MASTER_TX_BURST_EN
      hold_a[s] = 1'b0;
`endif
    end
    repeat (3) step();
    for (int s = 0; s < 2; s++) begin
      chk("rst_cs_n", cs_n_a[s], 1'b1);
      chk("rst_sck", sck_a[s], 1'b0);
      chk("rst_mosi", mosi_a[s], 1'b0);
      chk("rst_busy", busy_a[s], 1'b0);
      chk("rst_req", req_a[s], 1'b0);
      chk("rst_bus_out", bus_out_a[s], 8'h00);
    end
    rst = 1'b0;
    step();

    // Loopback, then all-zero transmit against an all-ones responder, at both dividers.
    xfer(0, 8'hA5, 8'h00, 1'b1);
    xfer(0, 8'h00, 8'hFF, 1'b0);
    xfer(1, 8'h00, 8'hFF, 1'b0);
    xfer(1, 8'hA5, 8'h00, 1'b1);

    for (int i = 0; i < 8; i++)
      xfer(i % 2, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));

    // Start held high with bus_in changing every cycle: only the word present when the
    // initiator is idle may be taken, and every deselect run is GAP (DIV) plus one idle cycle.
    start_a[0] = 1'b1;
    nacc = 0; hi = 0; pcs = 1'b1; seen_low = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      bus_in_a[0] = 8'($urandom);
      if (!busy_a[0]) begin
        q.push_back(bus_in_a[0]);
        nacc++;
      end
      miso_a[0] = mosi_a[0];
      step();
      if (req_a[0]) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 8'hxx;
        chk("stream_bus_out", bus_out_a[0], exp_w);
      end
      if (cs_n_a[0]) hi++;
      else if (pcs) begin
        if (seen_low) chk("stream_deselect_len", hi, DIVS[0] + 1);
        seen_low = 1'b1;
        hi = 0;
      end
      pcs = cs_n_a[0];
    end
    start_a[0] = 1'b0;
    guard = 0;
    while ((busy_a[0] || q.size() > 0) && guard < 200) begin
      miso_a[0] = mosi_a[0];
      step();
      guard++;
      if (req_a[0]) begin
        exp_w = (q.size() > 0) ? q.pop_front() : 8'hxx;
        chk("stream_drain_bus_out", bus_out_a[0], exp_w);
      end
    end
    chk("stream_drain_bound", guard < 200, 1'b1);
    chk("stream_accepted", nacc, 3);

    // Reset just after the 4th sck rise of a transfer.
    xfer(0, 8'hA5, 8'h00, 1'b1);
    bus_in_a[0] = 8'h5A;
    start_a[0]  = 1'b1;
    step();
    start_a[0] = 1'b0;
    rises = 0; psck = 1'b0; guard = 0;
    while (rises < 4 && guard < 200) begin
      miso_a[0] = mosi_a[0];
      step();
      guard++;
      if (sck_a[0] && !psck) rises++;
      psck = sck_a[0];
    end
    chk("rst_mid_reached", rises, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_cs_n", cs_n_a[0], 1'b1);
    chk("rst_mid_sck", sck_a[0], 1'b0);
    chk("rst_mid_busy", busy_a[0], 1'b0);
    chk("rst_mid_bus_out", bus_out_a[0], 8'h00);
    chk("rst_mid_mosi", mosi_a[0], 1'b0);
    step();
    xfer(0, 8'h3C, 8'h00, 1'b1);

`ifdef SPI_MASTER_TX_BURST_EN
    hold_a[0] = 1'b1;
    xfer(0, 8'h12, 8'h00, 1'b1);
    xfer(0, 8'h34, 8'h00, 1'b1);
    hold_a[0] = 1'b0;
    step();
    chk("burst_release_cs_n", cs_n_a[0], 1'b1);
    for (int k = 1; k < DIVS[0]; k++) begin
      chk("burst_gap_busy", busy_a[0], 1'b1);
      step();
    end
    step();
    chk("burst_idle_busy", busy_a[0], 1'b0);
    chk("burst_last_word", bus_out_a[0], 8'h34);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
